// File: rtl/spi_flash_reader_if.sv
// Request/response bundle between the control FSM and the SPI flash reader.
interface spi_flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        done;

    modport master (
        output start, addr, len,
        input  busy, data_out, data_valid, done
    );

    modport slave (
        input  start, addr, len,
        output busy, data_out, data_valid, done
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 read engine: issues READ (0x03) + 24-bit address, then streams
// len bytes back one at a time with a data_valid strobe.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_flash_reader_if.slave    host,
    output logic                 spi_csb,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DESEL
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [8:0] DIV_TC   = 9'(CLK_DIV - 1);
    localparam logic [8:0] HOLD_TC  = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nx;
    logic [8:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [30:0] tx_sr;
    logic [6:0]  rx_sr;
    logic        busy_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        done_q;

    logic active, tick, rise, fall, accept, hold_end;

    assign active   = (state == CMD) || (state == ADDR) || (state == DATA);
    assign tick     = active && (div_cnt == DIV_TC);
    assign rise     = tick && !spi_sclk;
    assign fall     = tick && spi_sclk;
    assign accept   = (state == IDLE) && host.start && (host.len != '0);
    assign hold_end = (state == DESEL) && (div_cnt == HOLD_TC);

    assign host.busy       = busy_q;
    assign host.data_out   = data_q;
    assign host.data_valid = valid_q;
    assign host.done       = done_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; phases advance only on falling SCLK edges
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                       state_nx = CMD;
            CMD:     if (fall && bit_cnt == 6'd7)      state_nx = ADDR;
            ADDR:    if (fall && bit_cnt == 6'd31)     state_nx = DATA;
            DATA:    if (fall && byte_cnt == '0)       state_nx = DESEL;
            DESEL:   if (hold_end)                     state_nx = IDLE;
            default:                                   state_nx = IDLE;
        endcase
    end

    // Divider, SCLK, shift registers, counters and host strobes.
    // The command MSB goes straight to spi_mosi at accept, so tx_sr only
    // holds the remaining 31 bits; zeros shift in behind the address and
    // keep spi_mosi low for the whole data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_csb  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (accept) begin
                busy_q   <= 1'b1;
                spi_csb  <= 1'b0;
                spi_sclk <= 1'b0;
                spi_mosi <= CMD_READ[7];
                tx_sr    <= {CMD_READ[6:0], host.addr};
                byte_cnt <= host.len;
                bit_cnt  <= '0;
                div_cnt  <= '0;
            end else if (active) begin
                div_cnt <= tick ? '0 : div_cnt + 9'd1;
                if (tick) spi_sclk <= ~spi_sclk;
                if (rise && state == DATA) begin
                    rx_sr <= {rx_sr[5:0], spi_miso};
                    if (bit_cnt[2:0] == 3'd7) begin
                        data_q   <= {rx_sr, spi_miso};
                        valid_q  <= 1'b1;
                        byte_cnt <= byte_cnt - 8'd1;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                if (fall) begin
                    if (state == DATA) begin
                        spi_mosi <= 1'b0;
                        if (byte_cnt == '0) spi_csb <= 1'b1;
                    end else begin
                        spi_mosi <= tx_sr[30];
                        tx_sr    <= {tx_sr[29:0], 1'b0};
                        bit_cnt  <= (bit_cnt == 6'd31) ? '0 : bit_cnt + 6'd1;
                    end
                end
            end else if (state == DESEL) begin
                if (hold_end) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    div_cnt <= div_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: one instance with CLK_DIV=2, one with CLK_DIV=1,
// each attached to a small behavioural READ-command flash model.
module tb_spi_flash_reader;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [23:0] addr_v;
    logic [7:0]  len_v;
    logic [7:0]  flash_data [4];

    wire [1:0]       busy_w, csb_w, sclk_w, mosi_w, dv_w, done_w;
    wire [1:0][7:0]  dout_w;

    int n_cmp;
    int n_err;
    int cyc;

    // Event log, filled on the falling clk edge
    int          dv_n   [2];
    int          dv_t   [2][32];
    logic [7:0]  dv_d   [2][32];
    int          done_n [2];
    int          done_t [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number of the most recent rising clk edge
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : fm
        localparam int unsigned DIV = (g == 0) ? 2 : 1;

        logic        miso;
        int          rise_cnt;
        int          last_rise;
        int          data_ones;
        int          last_ones;
        int          csb_falls;
        logic [31:0] mosi_word;
        logic [31:0] last_mosi;

        spi_flash_reader_if host ();

        assign host.start = start_v[g];
        assign host.addr  = addr_v;
        assign host.len   = len_v;
        assign busy_w[g]  = host.busy;
        assign dv_w[g]    = host.data_valid;
        assign done_w[g]  = host.done;
        assign dout_w[g]  = host.data_out;

        spi_flash_reader #(.CLK_DIV(DIV)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .host     (host),
            .spi_csb  (csb_w[g]),
            .spi_sclk (sclk_w[g]),
            .spi_mosi (mosi_w[g]),
            .spi_miso (miso)
        );

        // Flash side: sample MOSI on rising SCLK, snapshot totals when CSB rises
        always @(posedge sclk_w[g] or posedge csb_w[g]) begin
            if (csb_w[g]) begin
                if (rise_cnt != 0) begin
                    last_rise <= rise_cnt;
                    last_mosi <= mosi_word;
                    last_ones <= data_ones;
                end
                rise_cnt  <= 0;
                mosi_word <= '0;
                data_ones <= 0;
            end else begin
                rise_cnt <= rise_cnt + 1;
                if (rise_cnt < 32) mosi_word <= {mosi_word[30:0], mosi_w[g]};
                else if (mosi_w[g]) data_ones <= data_ones + 1;
            end
        end

        // Flash side: shift data out MSB first on falling SCLK after the address
        always @(negedge sclk_w[g]) begin
            if (rise_cnt >= 32 && (rise_cnt - 32) / 8 < 4)
                miso <= flash_data[(rise_cnt - 32) / 8][7 - ((rise_cnt - 32) % 8)];
            else
                miso <= 1'b0;
        end

        // Count chip-select assertions
        always @(negedge csb_w[g]) csb_falls <= csb_falls + 1;
    end

    // Log data_valid and done pulses with the cycle they appeared in
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (dv_w[g] === 1'b1) begin
                if (dv_n[g] < 32) begin
                    dv_t[g][dv_n[g]] <= cyc;
                    dv_d[g][dv_n[g]] <= dout_w[g];
                end
                dv_n[g] <= dv_n[g] + 1;
            end
            if (done_w[g] === 1'b1) begin
                done_n[g] <= done_n[g] + 1;
                done_t[g] <= cyc;
            end
        end
    end

    function automatic int f_last_rise(input int g);
        return (g == 0) ? fm[0].last_rise : fm[1].last_rise;
    endfunction

    function automatic logic [31:0] f_last_mosi(input int g);
        return (g == 0) ? fm[0].last_mosi : fm[1].last_mosi;
    endfunction

    function automatic int f_last_ones(input int g);
        return (g == 0) ? fm[0].last_ones : fm[1].last_ones;
    endfunction

    function automatic int f_csb_falls(input int g);
        return (g == 0) ? fm[0].csb_falls : fm[1].csb_falls;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One read on instance g; hold_start keeps start high until done
    task automatic do_read(input int g, input int div, input logic [23:0] a,
                           input logic [7:0] l, input bit hold_start, input string tag);
        int t0, b_dv, b_done, b_csb, nbits, limit, seen;
        @(posedge clk); #1;
        b_dv   = dv_n[g];
        b_done = done_n[g];
        b_csb  = f_csb_falls(g);
        nbits  = 32 + 8 * int'(l);
        limit  = 2 * nbits * div + 2 * div + 20;
        @(negedge clk);
        t0 = cyc + 1;
        addr_v     = a;
        len_v      = l;
        start_v[g] = 1'b1;
        @(negedge clk);
        if (!hold_start) start_v[g] = 1'b0;
        check_eq({tag, "_busy_t0"}, busy_w[g], 1);
        check_eq({tag, "_csb_t0"}, csb_w[g], 0);
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (done_w[g] === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        start_v[g] = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_busy_at_done"}, busy_w[g], 0);
        @(posedge clk); #1;
        check_eq({tag, "_mosi_hdr"}, f_last_mosi(g), {8'h03, a});
        check_eq({tag, "_mosi_data0"}, f_last_ones(g), 0);
        check_eq({tag, "_sclk_rises"}, f_last_rise(g), nbits);
        check_eq({tag, "_dv_count"}, dv_n[g] - b_dv, int'(l));
        for (int j = 1; j <= int'(l); j++) begin
            check_eq({tag, "_byte"}, dv_d[g][b_dv + j - 1], flash_data[j - 1]);
            check_eq({tag, "_dv_time"}, dv_t[g][b_dv + j - 1] - t0, (2 * (32 + 8 * j) - 1) * div);
        end
        check_eq({tag, "_done_count"}, done_n[g] - b_done, 1);
        check_eq({tag, "_done_time"}, done_t[g] - t0, 2 * nbits * div + 2 * div);
        check_eq({tag, "_csb_falls"}, f_csb_falls(g) - b_csb, 1);
        check_eq({tag, "_busy_after"}, busy_w[g], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_dv, b_done, b_csb, any_busy, any_csb, reached;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start_v = '0;
        addr_v  = '0;
        len_v   = '0;
        for (int i = 0; i < 4; i++) flash_data[i] = 8'h00;

        // Reset values
        #23;
        check_eq("rst_csb",   csb_w[0],  1);
        check_eq("rst_sclk",  sclk_w[0], 0);
        check_eq("rst_mosi",  mosi_w[0], 0);
        check_eq("rst_busy",  busy_w[0], 0);
        check_eq("rst_dout",  dout_w[0], 8'h00);
        check_eq("rst_dv",    dv_w[0],   0);
        check_eq("rst_done",  done_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: valid at T0+158, done at T0+164
        flash_data[0] = 8'h5A;
        do_read(0, 2, 24'h000000, 8'd1, 1'b0, "single");

        // Four-byte burst
        flash_data[0] = 8'hA1; flash_data[1] = 8'hB2;
        flash_data[2] = 8'hC3; flash_data[3] = 8'hD4;
        do_read(0, 2, 24'h012345, 8'd4, 1'b0, "burst");

        // start held high for the whole transaction
        flash_data[0] = 8'h3C;
        do_read(0, 2, 24'hABCDEF, 8'd1, 1'b1, "hold");

        // len=0 request must be ignored
        @(posedge clk); #1;
        b_done = done_n[0];
        b_csb  = f_csb_falls(0);
        @(negedge clk);
        len_v = 8'd0; addr_v = 24'h111111; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        any_busy = 0; any_csb = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_w[0] !== 1'b0) any_busy = 1;
            if (csb_w[0] !== 1'b1) any_csb = 1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        check_eq("len0_busy", any_busy, 0);
        check_eq("len0_csb",  any_csb,  0);
        check_eq("len0_done", done_n[0] - b_done, 0);
        check_eq("len0_csb_falls", f_csb_falls(0) - b_csb, 0);

        // Reset in the middle of the address phase
        b_dv   = dv_n[0];
        b_done = done_n[0];
        @(negedge clk);
        addr_v = 24'hFFFFF0; len_v = 8'd4; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            if (fm[0].rise_cnt >= 28) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_mid_reach", reached, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_csb",  csb_w[0],  1);
        check_eq("rst_mid_sclk", sclk_w[0], 0);
        check_eq("rst_mid_busy", busy_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        check_eq("rst_mid_no_dv",   dv_n[0] - b_dv,     0);
        check_eq("rst_mid_no_done", done_n[0] - b_done, 0);
        flash_data[0] = 8'h96;
        do_read(0, 2, 24'h00ABCD, 8'd1, 1'b0, "after_rst");

        // CLK_DIV=1, two bytes
        flash_data[0] = 8'h69; flash_data[1] = 8'hC3;
        do_read(1, 1, 24'h800001, 8'd2, 1'b0, "div1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
